// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// parameter defaults and the load-use match helper.
package hazard_ctrl_pkg;

   // Sequencer states; encodings are fixed so debug dumps stay comparable.
   typedef enum logic {
      StRun    = 1'b0,
      StMdBusy = 1'b1
   } hazState_t;

   localparam int unsigned MdLatencyDefault = 32;
   localparam int unsigned CntWDefault      = 6;
   localparam int unsigned PerfWDefault     = 16;

   // A load in EX feeds a source of the ID instruction; $zero never hazards.
   function automatic logic loadUseMatch(
      input logic       exMemRead,
      input logic [4:0] exRt,
      input logic [4:0] idRs,
      input logic [4:0] idRt,
      input logic       idUsesRt
   );
      return exMemRead && (exRt != 5'd0) &&
             ((exRt == idRs) || (idUsesRt && (exRt == idRt)));
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// master = pipeline side, slave = hazard controller.
interface hazard_ctrl_if #(
   parameter int unsigned PERF_W = 16
);

   logic [4:0]        id_rs;
   logic [4:0]        id_rt;
   logic              id_uses_rt;
   logic              id_md;
   logic              id_mfhilo;
   logic              ex_MemRead;
   logic [4:0]        ex_rt;
   logic              ex_branch_taken;
   logic              ex_jump;

   logic              pc_write;
   logic              ifid_write;
   logic              ifid_flush;
   logic              idex_flush;
   logic              md_start;
   logic              md_busy;
   logic [PERF_W-1:0] stall_count;

   modport master (
      output id_rs, id_rt, id_uses_rt, id_md, id_mfhilo,
      output ex_MemRead, ex_rt, ex_branch_taken, ex_jump,
      input  pc_write, ifid_write, ifid_flush, idex_flush,
      input  md_start, md_busy, stall_count
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, id_md, id_mfhilo,
      input  ex_MemRead, ex_rt, ex_branch_taken, ex_jump,
      output pc_write, ifid_write, ifid_flush, idex_flush,
      output md_start, md_busy, stall_count
   );

endinterface

// File: rtl/hazard_ctrl_md_busy_timer.sv
// Occupancy timer for the mult/div unit: loadable down-counter, done flag
// and a registered one-cycle start pulse.
module md_busy_timer #(
   parameter int unsigned MD_LATENCY = 32,
   parameter int unsigned CNT_W      = 6
) (
   input  logic CLK,
   input  logic RST,
   input  logic load,
   output logic done,
   output logic mdStart
);

   // Counter reaches zero in the last occupied cycle.
   localparam logic [CNT_W-1:0] LoadVal = CNT_W'(MD_LATENCY - 1);

   logic [CNT_W-1:0] cntQ, cntD;
   logic             startQ;

   // Next count: reload on accept, otherwise run down to zero and rest there.
   always_comb begin
      cntD = cntQ;
      if (load) begin
         cntD = LoadVal;
      end else if (cntQ != '0) begin
         cntD = cntQ - 1'b1;
      end
   end

   // Counter and start-pulse registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cntQ   <= '0;
         startQ <= 1'b0;
      end else begin
         cntQ   <= cntD;
         startQ <= load;
      end
   end

   assign done    = (cntQ == '0);
   assign mdStart = startQ;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: resolves branch/jump redirects, load-use
// stalls and structural stalls while the mult/div unit is occupied.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned MD_LATENCY = MdLatencyDefault,
   parameter int unsigned CNT_W      = CntWDefault,
   parameter int unsigned PERF_W     = PerfWDefault
) (
   input logic           CLK,
   input logic           RST,
   hazard_ctrl_if.slave  hz
);

   hazState_t         stateQ, stateD;
   logic              redirect, loadUse, mdHazard;
   logic              mdLoad, mdDone, mdStart;
   logic              pcWrite, ifidWrite, ifidFlush, idexFlush;
   logic [PERF_W-1:0] stallQ, stallD;

   md_busy_timer #(
      .MD_LATENCY (MD_LATENCY),
      .CNT_W      (CNT_W)
   ) uTimer (
      .CLK     (CLK),
      .RST     (RST),
      .load    (mdLoad),
      .done    (mdDone),
      .mdStart (mdStart)
   );

   // Hazard decode.
   always_comb begin
      redirect = hz.ex_branch_taken | hz.ex_jump;
      loadUse  = loadUseMatch(hz.ex_MemRead, hz.ex_rt, hz.id_rs, hz.id_rt, hz.id_uses_rt);
      mdHazard = (stateQ == StMdBusy) & (hz.id_md | hz.id_mfhilo);
   end

   // Pipeline control with priority redirect > load-use > mult/div hazard.
   always_comb begin
      pcWrite   = 1'b1;
      ifidWrite = 1'b1;
      ifidFlush = 1'b0;
      idexFlush = 1'b0;
      if (redirect) begin
         // ID instruction is wrong-path, so any stall it would cause is moot.
         ifidFlush = 1'b1;
         idexFlush = 1'b1;
      end else if (loadUse || mdHazard) begin
         pcWrite   = 1'b0;
         ifidWrite = 1'b0;
         idexFlush = 1'b1;
      end
   end

   // Sequencer next state; a mult/div enters EX only if it is not squashed or held.
   always_comb begin
      stateD = stateQ;
      mdLoad = 1'b0;
      unique case (stateQ)
         StRun: begin
            if (hz.id_md && !redirect && !loadUse) begin
               stateD = StMdBusy;
               mdLoad = 1'b1;
            end
         end
         StMdBusy: begin
            if (mdDone) begin
               stateD = StRun;
            end
         end
      endcase
   end

   // Saturating stall-cycle counter next value.
   always_comb begin
      stallD = stallQ;
      if (!pcWrite && (stallQ != {PERF_W{1'b1}})) begin
         stallD = stallQ + 1'b1;
      end
   end

   // State and performance registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         stateQ <= StRun;
         stallQ <= '0;
      end else begin
         stateQ <= stateD;
         stallQ <= stallD;
      end
   end

   assign hz.pc_write    = pcWrite;
   assign hz.ifid_write  = ifidWrite;
   assign hz.ifid_flush  = ifidFlush;
   assign hz.idex_flush  = idexFlush;
   assign hz.md_start    = mdStart;
   assign hz.md_busy     = (stateQ == StMdBusy);
   assign hz.stall_count = stallQ;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes expected outputs from a
// cycle-level reference model, a negedge monitor pops and compares.
module tb_hazard_ctrl;

   localparam int unsigned MdLat    = 4;
   localparam int unsigned CntW     = 3;
   localparam int unsigned PerfW    = 4;
   localparam int          StallMax = (1 << PerfW) - 1;

   logic CLK = 1'b0;
   logic RST = 1'b0;

   hazard_ctrl_if #(.PERF_W(PerfW)) bus ();

   hazard_ctrl #(
      .MD_LATENCY (MdLat),
      .CNT_W      (CntW),
      .PERF_W     (PerfW)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .hz  (bus.slave)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic pcWrite;
      logic ifidWrite;
      logic ifidFlush;
      logic idexFlush;
      logic mdStart;
      logic mdBusy;
      int   stall;
   } exp_t;

   exp_t sbQ[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model: cycles of occupancy left, pending start pulse, stall count.
   int   mdLeft    = 0;
   bit   startPend = 0;
   int   stallCnt  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
   always @(negedge CLK) begin
      exp_t e;
      if (sbQ.size() > 0) begin
         e = sbQ.pop_front();
         check("pc_write",    32'(bus.pc_write),    32'(e.pcWrite));
         check("ifid_write",  32'(bus.ifid_write),  32'(e.ifidWrite));
         check("ifid_flush",  32'(bus.ifid_flush),  32'(e.ifidFlush));
         check("idex_flush",  32'(bus.idex_flush),  32'(e.idexFlush));
         check("md_start",    32'(bus.md_start),    32'(e.mdStart));
         check("md_busy",     32'(bus.md_busy),     32'(e.mdBusy));
         check("stall_count", 32'(bus.stall_count), 32'(e.stall));
      end
   end

   task automatic setIn(input int rs, input int rt, input bit usesRt, input bit md,
                        input bit mfhilo, input bit memRead, input int exRt,
                        input bit br, input bit jmp);
      bus.id_rs           = 5'(rs);
      bus.id_rt           = 5'(rt);
      bus.id_uses_rt      = usesRt;
      bus.id_md           = md;
      bus.id_mfhilo       = mfhilo;
      bus.ex_MemRead      = memRead;
      bus.ex_rt           = 5'(exRt);
      bus.ex_branch_taken = br;
      bus.ex_jump         = jmp;
   endtask

   // One reset cycle: RST falls between edges, outputs must clear at once.
   task automatic resetCyc();
      exp_t e;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
      mdLeft    = 0;
      startPend = 0;
      stallCnt  = 0;
      e = '{pcWrite: 1, ifidWrite: 1, ifidFlush: 0, idexFlush: 0,
            mdStart: 0, mdBusy: 0, stall: 0};
      sbQ.push_back(e);
   endtask

   // One normal cycle: drive inputs, predict outputs, advance the model.
   task automatic cyc(input int rs, input int rt, input bit usesRt, input bit md,
                      input bit mfhilo, input bit memRead, input int exRt,
                      input bit br, input bit jmp);
      exp_t e;
      bit   redirect, lu, busy, mh, stall, accept;
      @(posedge CLK);
      #1;
      RST = 1'b1;
      setIn(rs, rt, usesRt, md, mfhilo, memRead, exRt, br, jmp);
      redirect = br || jmp;
      lu       = memRead && (exRt != 0) && ((exRt == rs) || (usesRt && (exRt == rt)));
      busy     = (mdLeft > 0);
      mh       = busy && (md || mfhilo);
      stall    = !redirect && (lu || mh);
      e.pcWrite   = !stall;
      e.ifidWrite = !stall;
      e.ifidFlush = redirect;
      e.idexFlush = redirect || stall;
      e.mdStart   = startPend;
      e.mdBusy    = busy;
      e.stall     = stallCnt;
      sbQ.push_back(e);
      if (stall && stallCnt < StallMax) stallCnt++;
      accept    = !busy && md && !redirect && !lu;
      startPend = accept;
      if (accept) mdLeft = MdLat;
      else if (busy) mdLeft--;
   endtask

   task automatic idle();
      cyc(1, 2, 1, 0, 0, 0, 0, 0, 0);
   endtask

   function automatic int pickReg();
      int r;
      r = int'($urandom_range(0, 3));
      return (r == 0) ? 0 : 4 + r;
   endfunction

   initial begin
      setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
      resetCyc();
      resetCyc();
      idle();
      idle();

      // Load-use stall, then the non-hazard variants.
      cyc(5, 1, 1, 0, 0, 1, 5, 0, 0);
      idle();
      cyc(0, 0, 1, 0, 0, 1, 0, 0, 0);
      cyc(3, 5, 0, 0, 0, 1, 5, 0, 0);
      cyc(3, 5, 1, 0, 0, 1, 5, 0, 0);

      // Redirect overrides load-use.
      cyc(5, 1, 1, 0, 0, 1, 5, 1, 0);
      cyc(5, 1, 1, 0, 0, 1, 5, 0, 1);

      // Occupancy: MFHI held through the busy window.
      cyc(1, 2, 1, 1, 0, 0, 0, 0, 0);
      repeat (5) cyc(1, 2, 0, 0, 1, 0, 0, 0, 0);
      idle();

      // Back-to-back mult/div.
      cyc(1, 2, 1, 1, 0, 0, 0, 0, 0);
      repeat (5) cyc(1, 2, 1, 1, 0, 0, 0, 0, 0);
      repeat (6) idle();

      // Redirect during busy: no stall, counter keeps running.
      cyc(1, 2, 1, 1, 0, 0, 0, 0, 0);
      cyc(1, 2, 1, 0, 1, 0, 0, 1, 0);
      repeat (5) idle();

      // Reset mid-occupancy.
      cyc(1, 2, 1, 1, 0, 0, 0, 0, 0);
      idle();
      resetCyc();
      idle();
      cyc(1, 2, 0, 0, 1, 0, 0, 0, 0);

      // Saturation of the stall counter.
      repeat (20) cyc(7, 0, 0, 0, 0, 1, 7, 0, 0);
      idle();
      idle();

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            resetCyc();
         end else begin
            cyc(pickReg(), pickReg(), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 2) == 0), pickReg(),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 15) == 0));
         end
      end

      @(negedge CLK);
      #1;
      check("sb_drain", 32'(sbQ.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
